// File: rtl/mmu_responder_pkg.sv
// mmu_responder_pkg: state encoding and region/timeout constants shared by the responder.
package mmu_responder_pkg;

    typedef enum logic [1:0] {IDLE, RAM_RD, MMIO_WAIT, DONE} state_e;

    localparam logic [31:0] MMIO_BASE_DFLT    = 32'hFFFF_0000;
    localparam int unsigned MMIO_TIMEOUT_DFLT = 255;
    localparam logic [31:0] TIMEOUT_DATA      = 32'hDEAD_BEEF;

endpackage

// File: rtl/mmu_responder_ram.sv
// mmu_ram: single-port synchronous RAM, registered read, write-first.
module mmu_ram #(
    parameter int unsigned WORDS = 16384,
    localparam int AW = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata_q   <= wdata;
            end else begin
                rdata_q   <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mmu_responder.sv
// mmu_responder: serves L1 miss traffic from on-chip RAM, an MMIO port, or an unmapped stub.
module mmu_responder
    import mmu_responder_pkg::*;
#(
    parameter int unsigned RAM_WORDS    = 16384,
    parameter logic [31:0] MMIO_BASE    = MMIO_BASE_DFLT,
    parameter int unsigned MMIO_TIMEOUT = MMIO_TIMEOUT_DFLT
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        l1_mmu_req,
    input  logic        l1_mmu_req_read,
    input  logic        l1_mmu_req_write,
    input  logic [31:0] l1_mmu_req_addr,
    input  logic [31:0] l1_mmu_write_data,
    output logic        mmu_l1_read_done,
    output logic        mmu_l1_write_done,
    output logic        mmu_l1_volatile,
    output logic [31:0] mmu_l1_read_data,
    output logic        mmio_req,
    output logic        mmio_we,
    output logic [31:0] mmio_addr,
    output logic [31:0] mmio_wdata,
    input  logic [31:0] mmio_rdata,
    input  logic        mmio_ack
);

    localparam int AW = $clog2(RAM_WORDS);

    state_e      state_q, state_d;
    logic        post_q, post_d;
    logic        blocked_q, blocked_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] cnt_q, cnt_d;
    logic        read_done_q, read_done_d;
    logic        write_done_q, write_done_d;
    logic        volatile_q, volatile_d;
    logic [31:0] read_data_q, read_data_d;
    logic        mmio_req_q, mmio_req_d;

    logic        hit_ram, hit_mmio, take, ram_en, finish;
    logic [31:0] ram_rdata;

    assign hit_ram  = {1'b0, l1_mmu_req_addr} < (33'(RAM_WORDS) << 2);
    assign hit_mmio = l1_mmu_req_addr >= MMIO_BASE;
    // blocked_q keeps a request still held after its done from being served twice
    assign take     = state_q == IDLE && !post_q && !blocked_q && l1_mmu_req
                      && (l1_mmu_req_read || l1_mmu_req_write);
    assign ram_en   = take && hit_ram;
    assign finish   = mmio_ack || cnt_q == 32'(MMIO_TIMEOUT - 1);

    mmu_ram #(.WORDS(RAM_WORDS)) u_ram (
        .clk   (sys_clk),
        .en    (ram_en),
        .we    (l1_mmu_req_write),
        .addr  (l1_mmu_req_addr[AW+1:2]),
        .wdata (l1_mmu_write_data),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d      = state_q;
        post_d       = 1'b0;
        blocked_d    = blocked_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        read_done_d  = 1'b0;
        write_done_d = 1'b0;
        volatile_d   = volatile_q;
        read_data_d  = read_data_q;
        mmio_req_d   = mmio_req_q;
        case (state_q)
            IDLE: begin
                blocked_d = blocked_q && l1_mmu_req;
                if (take) begin
                    we_d    = l1_mmu_req_write;
                    addr_d  = l1_mmu_req_addr;
                    wdata_d = l1_mmu_write_data;
                    if (hit_ram) begin
                        state_d      = l1_mmu_req_write ? DONE : RAM_RD;
                        write_done_d = l1_mmu_req_write;
                        read_data_d  = l1_mmu_req_write ? l1_mmu_write_data : read_data_q;
                        volatile_d   = l1_mmu_req_write ? 1'b0 : volatile_q;
                    end else if (hit_mmio) begin
                        state_d    = MMIO_WAIT;
                        mmio_req_d = 1'b1;
                    end else begin
                        state_d      = DONE;
                        read_done_d  = !l1_mmu_req_write;
                        write_done_d = l1_mmu_req_write;
                        read_data_d  = 32'h0;
                        volatile_d   = 1'b1;
                    end
                end
            end
            RAM_RD: begin
                state_d     = DONE;
                read_done_d = 1'b1;
                read_data_d = ram_rdata;
                volatile_d  = 1'b0;
            end
            MMIO_WAIT: begin
                cnt_d = finish ? 32'h0 : cnt_q + 32'd1;
                if (finish) begin
                    state_d      = DONE;
                    mmio_req_d   = 1'b0;
                    read_done_d  = !we_q;
                    write_done_d = we_q;
                    read_data_d  = mmio_ack ? mmio_rdata : TIMEOUT_DATA;
                    volatile_d   = 1'b1;
                end
            end
            DONE: begin
                state_d   = IDLE;
                post_d    = 1'b1;
                blocked_d = l1_mmu_req;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            post_q       <= 1'b0;
            blocked_q    <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            cnt_q        <= 32'h0;
            read_done_q  <= 1'b0;
            write_done_q <= 1'b0;
            volatile_q   <= 1'b0;
            read_data_q  <= 32'h0;
            mmio_req_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            post_q       <= post_d;
            blocked_q    <= blocked_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            read_done_q  <= read_done_d;
            write_done_q <= write_done_d;
            volatile_q   <= volatile_d;
            read_data_q  <= read_data_d;
            mmio_req_q   <= mmio_req_d;
        end
    end

    assign mmu_l1_read_done  = read_done_q;
    assign mmu_l1_write_done = write_done_q;
    assign mmu_l1_volatile   = volatile_q;
    assign mmu_l1_read_data  = read_data_q;
    assign mmio_req          = mmio_req_q;
    assign mmio_we           = we_q;
    assign mmio_addr         = addr_q;
    assign mmio_wdata        = wdata_q;

endmodule
